// File: rtl/rng_sched_pkg.sv
// Shared types and constants for the LFSR-backed round-robin scheduler.
// Default LFSR width, feedback tap positions and the scheduler FSM encoding.
package rng_sched_pkg;

    localparam int DEF_BITWIDTH = 5;
    localparam int TAP_LO       = 0;
    localparam int TAP_HI       = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    // Bits needed for a counter that runs 0..n-1.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rng_lfsr_core.sv
// Fibonacci LFSR for x^5+x^3+1: the feedback bit enters at the MSB.
// A load has priority over a step; the state resets to 1.
module rng_lfsr_core
    import rng_sched_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                step_en,
    input  logic                load_en,
    input  logic [BITWIDTH-1:0] load_val,
    output logic [BITWIDTH-1:0] lfsr,
    output logic [BITWIDTH-1:0] lfsr_next
);

    assign lfsr_next = {lfsr[TAP_LO] ^ lfsr[TAP_HI], lfsr[BITWIDTH-1:1]};

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            lfsr <= BITWIDTH'(1);
        end else if (load_en) begin
            lfsr <= load_val;
        end else if (step_en) begin
            lfsr <= lfsr_next;
        end
    end

endmodule

// File: rtl/rng_scheduler.sv
// Round-robin grant scheduler that hands each winner a fresh LFSR value.
// Optional zero-seed guard: define RNG_SCHED_ZERO_GUARD_EN.
module rng_scheduler
    import rng_sched_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int NREQ     = 4,
    parameter int STEPS    = 1
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic [NREQ-1:0]     req,
    input  logic                seed_load,
    input  logic [BITWIDTH-1:0] seed,
    output logic [NREQ-1:0]     gnt,
    output logic                rvalid,
    output logic [BITWIDTH-1:0] rdata,
    output logic                busy,
    output logic                seed_err,
    output sched_state_t        fsm_state
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = cnt_width(STEPS);

    // gnt/rvalid form a one-cycle pulse with no back-pressure: the consumer
    // must take rdata in the cycle rvalid is high; rdata holds otherwise.

    sched_state_t       state;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      sel;
    logic               sel_ok;
    logic [CW-1:0]      cnt;
    logic [BITWIDTH-1:0] lfsr;
    logic [BITWIDTH-1:0] lfsr_next;
    logic [BITWIDTH-1:0] load_val;
    logic               step_en;
    logic               load_en;

    assign step_en   = (state == SHIFT);
    assign load_en   = (state == IDLE) && seed_load;
    assign busy      = (state != IDLE);
    assign fsm_state = state;

`ifdef RNG_SCHED_ZERO_GUARD_EN
    assign load_val = (seed == '0) ? BITWIDTH'(1) : seed;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            seed_err <= 1'b0;
        end else begin
            seed_err <= (state == IDLE) && seed_load && (seed == '0);
        end
    end
`else
    assign load_val = seed;
    assign seed_err = 1'b0;
`endif

    rng_lfsr_core #(
        .BITWIDTH (BITWIDTH)
    ) u_lfsr (
        .clk       (clk),
        .arst_n    (arst_n),
        .step_en   (step_en),
        .load_en   (load_en),
        .load_val  (load_val),
        .lfsr      (lfsr),
        .lfsr_next (lfsr_next)
    );

    // First set request at or above rr_ptr, wrapping past NREQ-1.
    always_comb begin : arb
        int j;
        sel    = '0;
        sel_ok = 1'b0;
        j      = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(rr_ptr) + i) % NREQ;
            if (!sel_ok && req[j]) begin
                sel    = IW'(j);
                sel_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            idx    <= '0;
            cnt    <= '0;
            gnt    <= '0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gnt    <= '0;
                    rvalid <= 1'b0;
                    if (!seed_load && sel_ok) begin
                        idx   <= sel;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The final step lands in the LFSR on this same edge, so
                    // the delivered value is taken from lfsr_next.
                    if (cnt == CW'(STEPS - 1)) begin
                        state  <= DONE;
                        gnt    <= NREQ'(1) << idx;
                        rvalid <= 1'b1;
                        rdata  <= lfsr_next;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    gnt    <= '0;
                    rvalid <= 1'b0;
                    rr_ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_scheduler.sv
// Self-checking bench for rng_scheduler (BITWIDTH=5, NREQ=4, STEPS=1).
// Reference model works on integers: polynomial feedback and a rotating pointer.
module tb_rng_scheduler;
    import rng_sched_pkg::*;

    localparam int BW    = 5;
    localparam int NREQ  = 4;
    localparam int STEPS = 1;

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic            seed_load = 1'b0;
    logic [BW-1:0]   seed = '0;
    logic [NREQ-1:0] gnt;
    logic            rvalid;
    logic [BW-1:0]   rdata;
    logic            busy;
    logic            seed_err;
    sched_state_t    fsm_state;

    int vectors = 0;
    int miscompares = 0;
    int m_lfsr = 1;
    int m_rr = 0;
    logic [BW-1:0] exp_q[$];

    rng_scheduler #(.BITWIDTH(BW), .NREQ(NREQ), .STEPS(STEPS)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .req       (req),
        .seed_load (seed_load),
        .seed      (seed),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .busy      (busy),
        .seed_err  (seed_err),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int m_adv(input int s);
        int v;
        v = s;
        for (int k = 0; k < STEPS; k++) begin
            v = (v >> 1) | (((v ^ (v >> 2)) & 1) << (BW - 1));
        end
        return v & ((1 << BW) - 1);
    endfunction

    function automatic int m_pick(input logic [NREQ-1:0] r, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic m_grant(input logic [NREQ-1:0] r, output logic [NREQ-1:0] eg,
                           output logic [BW-1:0] ed);
        int k;
        k = m_pick(r, m_rr);
        m_lfsr = m_adv(m_lfsr);
        eg = NREQ'(1 << k);
        ed = BW'(m_lfsr);
        m_rr = (k + 1) % NREQ;
    endtask

    task automatic m_seed(input int s);
`ifdef RNG_SCHED_ZERO_GUARD_EN
        m_lfsr = (s == 0) ? 1 : s;
`else
        m_lfsr = s;
`endif
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        req = '0;
        seed_load = 1'b0;
        arst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        m_lfsr = 1;
        m_rr = 0;
    endtask

    task automatic load_seed(input logic [BW-1:0] s);
        seed_load = 1'b1;
        seed = s;
        @(negedge clk);
        seed_load = 1'b0;
        m_seed(int'(s));
    endtask

    // Called at a negedge while the DUT is idle; returns at the rvalid negedge.
    task automatic run_grant(input logic [NREQ-1:0] r, input bit keep,
                             output logic [NREQ-1:0] g, output logic [BW-1:0] d,
                             output int lat);
        req = r;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (!keep) req = '0;
            if (rvalid) break;
        end
        g = gnt;
        d = rdata;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        req = '0;
        seed_load = 1'b0;
        arst_n = 1'b0;
        @(negedge clk);
        vectors++; if (gnt !== '0) begin miscompares++; $display("FAIL reset_gnt: got %b want 0", gnt); end
        vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
        vectors++; if (rdata !== '0) begin miscompares++; $display("FAIL reset_rdata: got %0d want 0", rdata); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (seed_err !== 1'b0) begin miscompares++; $display("FAIL reset_seed_err: got %b want 0", seed_err); end
        vectors++; if (fsm_state !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want IDLE", fsm_state); end
        arst_n = 1'b1;
        m_lfsr = 1;
        m_rr = 0;
    endtask

    task automatic test_first_grants();
        logic [NREQ-1:0] g, eg;
        logic [BW-1:0] d, ed;
        int lat;
        do_reset();
        for (int n = 0; n < 2; n++) begin
            run_grant(4'b0001, 1'b0, g, d, lat);
            m_grant(4'b0001, eg, ed);
            vectors++; if (lat !== STEPS + 1) begin miscompares++; $display("FAIL first_latency: got %0d want %0d", lat, STEPS + 1); end
            vectors++; if (g !== eg) begin miscompares++; $display("FAIL first_gnt: got %b want %b", g, eg); end
            vectors++; if (d !== ed) begin miscompares++; $display("FAIL first_rdata: got %0d want %0d", d, ed); end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] eg;
        logic [BW-1:0] ed, held;
        int last, n;
        do_reset();
        held = '0;
        last = -1;
        n = 0;
        req = 4'hF;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            @(negedge clk);
            if (rvalid) begin
                m_grant(4'hF, eg, ed);
                vectors++; if (gnt !== eg) begin miscompares++; $display("FAIL rr_gnt: got %b want %b", gnt, eg); end
                vectors++; if (rdata !== ed) begin miscompares++; $display("FAIL rr_rdata: got %0d want %0d", rdata, ed); end
                if (n > 0) begin
                    vectors++; if (cyc - last !== STEPS + 2) begin miscompares++; $display("FAIL rr_spacing: got %0d want %0d", cyc - last, STEPS + 2); end
                end
                held = ed;
                last = cyc;
                n++;
            end else begin
                vectors++; if (gnt !== '0) begin miscompares++; $display("FAIL rr_gnt_idle: got %b want 0", gnt); end
                vectors++; if (rdata !== held) begin miscompares++; $display("FAIL rr_rdata_hold: got %0d want %0d", rdata, held); end
            end
        end
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL rr_count: got %0d want 5", n); end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_seed();
        logic [NREQ-1:0] g, eg;
        logic [BW-1:0] d, ed;
        int lat;
        do_reset();
        load_seed(5'd5);
        run_grant(4'b0100, 1'b0, g, d, lat);
        m_grant(4'b0100, eg, ed);
        vectors++; if (g !== eg) begin miscompares++; $display("FAIL seed_gnt: got %b want %b", g, eg); end
        vectors++; if (d !== ed) begin miscompares++; $display("FAIL seed_rdata: got %0d want %0d", d, ed); end
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        req = '0;
        seed_load = 1'b1;
        seed = 5'd9;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL seed_busy: got %b want 1", busy); end
        @(negedge clk);
        seed_load = 1'b0;
        m_grant(4'b0001, eg, ed);
        vectors++; if (rvalid !== 1'b1) begin miscompares++; $display("FAIL seed_shift_rvalid: got %b want 1", rvalid); end
        vectors++; if (gnt !== eg) begin miscompares++; $display("FAIL seed_shift_gnt: got %b want %b", gnt, eg); end
        vectors++; if (rdata !== ed) begin miscompares++; $display("FAIL seed_shift_ignored: got %0d want %0d", rdata, ed); end
        @(negedge clk);
    endtask

    task automatic test_zero_seed();
        logic [NREQ-1:0] g, eg;
        logic [BW-1:0] d, ed;
        int lat;
        do_reset();
        load_seed(5'd0);
`ifdef RNG_SCHED_ZERO_GUARD_EN
        vectors++; if (seed_err !== 1'b1) begin miscompares++; $display("FAIL zero_seed_err: got %b want 1", seed_err); end
`else
        vectors++; if (seed_err !== 1'b0) begin miscompares++; $display("FAIL zero_seed_err: got %b want 0", seed_err); end
`endif
        @(negedge clk);
        vectors++; if (seed_err !== 1'b0) begin miscompares++; $display("FAIL zero_seed_err_pulse: got %b want 0", seed_err); end
        run_grant(4'b0010, 1'b0, g, d, lat);
        m_grant(4'b0010, eg, ed);
        vectors++; if (d !== ed) begin miscompares++; $display("FAIL zero_rdata1: got %0d want %0d", d, ed); end
        @(negedge clk);
        run_grant(4'b0001, 1'b0, g, d, lat);
        m_grant(4'b0001, eg, ed);
        vectors++; if (d !== ed) begin miscompares++; $display("FAIL zero_rdata2: got %0d want %0d", d, ed); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        logic [NREQ-1:0] g, eg;
        logic [BW-1:0] d, ed;
        int lat;
        do_reset();
        run_grant(4'b0001, 1'b0, g, d, lat);
        m_grant(4'b0001, eg, ed);
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        vectors++; if (fsm_state !== SHIFT) begin miscompares++; $display("FAIL mid_state: got %0d want SHIFT", fsm_state); end
        arst_n = 1'b0;
        #1;
        vectors++; if (gnt !== '0) begin miscompares++; $display("FAIL mid_gnt: got %b want 0", gnt); end
        vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("FAIL mid_rvalid: got %b want 0", rvalid); end
        vectors++; if (rdata !== '0) begin miscompares++; $display("FAIL mid_rdata: got %0d want 0", rdata); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
        @(negedge clk);
        arst_n = 1'b1;
        m_lfsr = 1;
        m_rr = 0;
        run_grant(4'b1010, 1'b0, g, d, lat);
        m_grant(4'b1010, eg, ed);
        vectors++; if (g !== eg) begin miscompares++; $display("FAIL mid_after_gnt: got %b want %b", g, eg); end
        vectors++; if (d !== ed) begin miscompares++; $display("FAIL mid_after_rdata: got %0d want %0d", d, ed); end
        @(negedge clk);
    endtask

    task automatic test_period();
        logic [NREQ-1:0] g, eg;
        logic [BW-1:0] d, ed;
        logic [BW-1:0] vals[32];
        int lat;
        bit dup;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            run_grant(4'hF, 1'b1, g, d, lat);
            m_grant(4'hF, eg, ed);
            vals[i] = d;
            vectors++; if (d !== ed) begin miscompares++; $display("FAIL period_rdata[%0d]: got %0d want %0d", i, d, ed); end
            @(negedge clk);
        end
        req = '0;
        for (int i = 0; i < 31; i++) begin
            dup = 1'b0;
            for (int j = 0; j < i; j++) if (vals[j] == vals[i]) dup = 1'b1;
            vectors++;
            if (vals[i] == '0 || dup) begin
                miscompares++;
                $display("FAIL period_distinct[%0d]: got %0d dup=%0d want nonzero unique", i, vals[i], dup);
            end
        end
        vectors++; if (vals[31] !== vals[0]) begin miscompares++; $display("FAIL period_wrap: got %0d want %0d", vals[31], vals[0]); end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] g, eg, r;
        logic [BW-1:0] d, ed, e;
        int lat;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) load_seed(BW'($urandom_range(1, 31)));
            r = NREQ'($urandom_range(1, 15));
            run_grant(r, 1'b0, g, d, lat);
            m_grant(r, eg, ed);
            exp_q.push_back(ed);
            e = exp_q.pop_front();
            vectors++; if (lat !== STEPS + 1) begin miscompares++; $display("FAIL rand_latency: got %0d want %0d", lat, STEPS + 1); end
            vectors++; if (g !== eg) begin miscompares++; $display("FAIL rand_gnt: req %b got %b want %b", r, g, eg); end
            vectors++; if (d !== e) begin miscompares++; $display("FAIL rand_rdata: got %0d want %0d", d, e); end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_grants();
        test_round_robin();
        test_seed();
        test_zero_seed();
        test_reset_mid_shift();
        test_period();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rng_scheduler.md
RNG_SCHEDULER -- requirements
Module: rng_scheduler

Interface
REQ-001 Parameter BITWIDTH, default 5, width of the pseudo-random state and delivered value; only value 5 is supported.
REQ-002 Parameter NREQ, default 4, number of requesters; legal range 2..8.
REQ-003 Parameter STEPS, default 1, LFSR advances per grant; legal range 1..BITWIDTH.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 arst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester request level.
REQ-007 seed_load  input  1  load seed into the LFSR state, single-cycle pulse.
REQ-008 seed  input  BITWIDTH  seed value.
REQ-009 gnt  output  NREQ  one-hot grant pulse.
REQ-010 rvalid  output  1  rdata valid, coincident with gnt.
REQ-011 rdata  output  BITWIDTH  delivered random value.
REQ-012 busy  output  1  high when the FSM is not IDLE.
REQ-013 seed_err  output  1  single-cycle pulse flagging a zero seed (RNG_SCHED_ZERO_GUARD_EN only; tied 0 otherwise).

Function
REQ-014 The LFSR step SHALL be next = {s[0]^s[2], s[4], s[3], s[2], s[1]} (x^5+x^3+1, period 31).
REQ-015 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-016 In IDLE, seed_load SHALL take priority: state <= seed, FSM stays in IDLE, no grant is issued that cycle.
REQ-017 In IDLE with no seed_load and req != 0, the arbiter SHALL select the first set req bit scanning upward from rr_ptr with wrap, latch its index, and go to SHIFT.
REQ-018 In SHIFT, the LFSR SHALL advance once per cycle for exactly STEPS cycles, then the FSM SHALL go to DONE.
REQ-019 In DONE, for exactly one cycle: gnt[idx]=1, rvalid=1, rdata=LFSR state; rr_ptr <= (idx+1) mod NREQ; next state is IDLE.
REQ-020 Latency from req sampled in IDLE at edge t to gnt/rvalid high SHALL be STEPS+1 cycles; throughput is one grant per STEPS+2 cycles.
REQ-021 A selected grant SHALL complete even if its req drops during SHIFT.
REQ-022 seed_load outside IDLE SHALL be ignored.
REQ-023 rdata SHALL hold its last value while rvalid=0; gnt SHALL be 0 outside DONE.
REQ-024 The LFSR SHALL not advance in IDLE or DONE.

Reset
REQ-025 On arst_n low, immediately: LFSR=1, state=IDLE, rr_ptr=0, gnt=0, rvalid=0, rdata=0, busy=0, seed_err=0, including mid-SHIFT/DONE.
REQ-026 After reset release, the first grant SHALL go to the lowest set req bit scanning from 0.

Configuration
REQ-027 With RNG_SCHED_ZERO_GUARD_EN defined, a seed_load of 0 SHALL load 1 instead and pulse seed_err for one cycle.
REQ-028 Without RNG_SCHED_ZERO_GUARD_EN, a zero seed SHALL be loaded as-is (the LFSR locks at 0), and seed_err SHALL be constant 0.

Structure
REQ-029 Package rng_sched_pkg SHALL hold the FSM state enum and the default constants for BITWIDTH and the tap positions (0, 2).
REQ-030 LFSR state and step SHALL live in sub-module rng_lfsr_core with inputs step_en, load_en, load_val.
REQ-031 The round-robin selection SHALL be combinational inside rng_scheduler.

Verification (BITWIDTH=5, NREQ=4, STEPS=1)
REQ-032 Reset, then pulse req=4'b0001 -> gnt=4'b0001, rdata=16 two cycles later; second request -> rdata=8.
REQ-033 Hold req=4'b1111 -> gnt sequence 0001,0010,0100,1000,0001, one every 3 cycles.
REQ-034 seed_load with seed=5 in IDLE, then req[2] -> rdata=2; seed_load asserted during SHIFT -> ignored.
REQ-035 seed=0 with guard -> seed_err pulse, next rdata=16; without guard -> rdata=0 repeatedly.
REQ-036 Assert arst_n low during SHIFT -> all outputs 0 and busy=0 at once; the next grant after release goes to the lowest req bit with rdata=16.
REQ-037 31 consecutive grants from reset -> 31 distinct nonzero rdata values; the 32nd equals the 1st.
